// File: rtl/f2c_req_queue.sv
// F2C request queue: buffers rc requests, issues them one at a time to the
// DE10-Lite peripheral register block and returns responses in request order.

package f2c_req_queue_pkg;
    typedef enum logic [1:0] {
        RD     = 2'd0,
        WR     = 2'd1,
        RD_RSP = 2'd2,
        WR_RSP = 2'd3
    } t_opcode;
endpackage

module f2c_req_queue
    import f2c_req_queue_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int RD_TIMEOUT = 255
) (
    input  logic                   QClk,
    input  logic                   RstQnnnH,
    input  logic                   F2C_ReqValidQ502H,
    input  t_opcode                F2C_ReqOpcodeQ502H,
    input  logic [31:0]            F2C_ReqAddressQ502H,
    input  logic [31:0]            F2C_ReqDataQ502H,
    output logic                   F2C_RspValidQ500H,
    output t_opcode                F2C_RspOpcodeQ500H,
    output logic [31:0]            F2C_RspAddressQ500H,
    output logic [31:0]            F2C_RspDataQ500H,
    output logic                   PrphReqValid,
    output logic                   PrphReqWr,
    output logic [31:0]            PrphReqAddress,
    output logic [31:0]            PrphReqData,
    input  logic                   PrphReqReady,
    input  logic                   PrphRdDataValid,
    input  logic [31:0]            PrphRdData,
    output logic [$clog2(DEPTH):0] QueueCount,
    output logic                   OverflowSticky,
    output logic                   TimeoutSticky
);

    localparam int               AW         = $clog2(DEPTH);
    localparam int               TW         = $clog2(RD_TIMEOUT + 1);
    localparam logic [AW:0]      FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0]    TIMER_LAST = TW'(RD_TIMEOUT - 1);

    typedef struct packed {
        t_opcode     op;
        logic [31:0] addr;
        logic [31:0] data;
    } t_entry;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        RSP
    } t_state;

    t_entry        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    t_state        state;
    logic [TW-1:0] timer;
    logic [31:0]   cur_addr;

    logic req_ok;
    logic full;
    logic pop;
    logic push;

    always_comb begin
        req_ok = F2C_ReqValidQ502H &&
                 (F2C_ReqOpcodeQ502H == RD || F2C_ReqOpcodeQ502H == WR);
        full   = (QueueCount == FULL_COUNT);
        pop    = (state == ISSUE) && PrphReqValid && PrphReqReady;
        // A full queue still takes a push when the head leaves in the same cycle.
        push   = req_ok && (!full || pop);
    end

    // NOTE: storage is not reset; pointers and count define which entries are live.
    always_ff @(posedge QClk) begin
        if (push) begin
            mem[wr_ptr] <= '{op: F2C_ReqOpcodeQ502H,
                             addr: F2C_ReqAddressQ502H,
                             data: F2C_ReqDataQ502H};
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge QClk) begin
        if (RstQnnnH) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            QueueCount     <= '0;
            OverflowSticky <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop) begin
                QueueCount <= QueueCount + (AW + 1)'(1);
            end else if (pop && !push) begin
                QueueCount <= QueueCount - (AW + 1)'(1);
            end
            if (req_ok && full && !pop) OverflowSticky <= 1'b1;
        end
    end

    always_ff @(posedge QClk) begin
        if (RstQnnnH) begin
            state               <= IDLE;
            timer               <= '0;
            cur_addr            <= '0;
            PrphReqValid        <= 1'b0;
            PrphReqWr           <= 1'b0;
            PrphReqAddress      <= '0;
            PrphReqData         <= '0;
            F2C_RspValidQ500H   <= 1'b0;
            F2C_RspOpcodeQ500H  <= RD;
            F2C_RspAddressQ500H <= '0;
            F2C_RspDataQ500H    <= '0;
            TimeoutSticky       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (QueueCount != '0) begin
                        state          <= ISSUE;
                        PrphReqValid   <= 1'b1;
                        PrphReqWr      <= (mem[rd_ptr].op == WR);
                        PrphReqAddress <= mem[rd_ptr].addr;
                        PrphReqData    <= mem[rd_ptr].data;
                    end
                end

                ISSUE: begin
                    if (PrphReqReady) begin
                        PrphReqValid   <= 1'b0;
                        PrphReqWr      <= 1'b0;
                        PrphReqAddress <= '0;
                        PrphReqData    <= '0;
                        cur_addr       <= PrphReqAddress;
                        timer          <= '0;
                        if (PrphReqWr) begin
                            state               <= RSP;
                            F2C_RspValidQ500H   <= 1'b1;
                            F2C_RspOpcodeQ500H  <= WR_RSP;
                            F2C_RspAddressQ500H <= PrphReqAddress;
                            F2C_RspDataQ500H    <= '0;
                        end else begin
                            state <= WAIT_RD;
                        end
                    end
                end

                WAIT_RD: begin
                    // A return arriving on the final allowed cycle still wins over the timeout.
                    if (PrphRdDataValid || timer == TIMER_LAST) begin
                        state               <= RSP;
                        F2C_RspValidQ500H   <= 1'b1;
                        F2C_RspOpcodeQ500H  <= RD_RSP;
                        F2C_RspAddressQ500H <= cur_addr;
                        F2C_RspDataQ500H    <= PrphRdDataValid ? PrphRdData : 32'hDEAD_BEEF;
                        if (!PrphRdDataValid) TimeoutSticky <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                RSP: begin
                    state               <= IDLE;
                    F2C_RspValidQ500H   <= 1'b0;
                    F2C_RspOpcodeQ500H  <= RD;
                    F2C_RspAddressQ500H <= '0;
                    F2C_RspDataQ500H    <= '0;
                end

                default: state <= IDLE;
            endcase
        end
    end

    a_prph_stable: assert property (@(posedge QClk) disable iff (RstQnnnH)
        PrphReqValid && !PrphReqReady |=>
            PrphReqValid && $stable({PrphReqWr, PrphReqAddress, PrphReqData}));

    a_count_bound: assert property (@(posedge QClk) disable iff (RstQnnnH)
        QueueCount <= FULL_COUNT);

endmodule

// File: doc/f2c_req_queue.md
F2C_REQ_QUEUE -- requirements
Module: f2c_req_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4 (power of two, 2..16), meaning request queue entries.
REQ-002 SHALL have parameter RD_TIMEOUT, default 255, meaning max WAIT_RD cycles before a forced read response.
REQ-003 SHALL have one clock and a synchronous, active-high reset: QClk  input  1  clock; RstQnnnH  input  1  synchronous active-high reset.
REQ-004 F2C_ReqValidQ502H  input  1  request strobe from rc; there is no backpressure toward rc.
REQ-005 F2C_ReqOpcodeQ502H  input  t_opcode  request opcode (RD or WR).
REQ-006 F2C_ReqAddressQ502H  input  32  request address.
REQ-007 F2C_ReqDataQ502H  input  32  write data.
REQ-008 F2C_RspValidQ500H  output  1  one-cycle response strobe to rc.
REQ-009 F2C_RspOpcodeQ500H  output  t_opcode  RD_RSP or WR_RSP.
REQ-010 F2C_RspAddressQ500H / F2C_RspDataQ500H  output  32 each  echoed request address / read data.
REQ-011 PrphReqValid  output  1; PrphReqWr  output  1; PrphReqAddress  output  32; PrphReqData  output  32: request to the DE10-Lite peripheral register block.
REQ-012 PrphReqReady  input  1: peripheral accepts the request when PrphReqValid && PrphReqReady.
REQ-013 PrphRdDataValid  input  1; PrphRdData  input  32: read return.
REQ-014 QueueCount  output  $clog2(DEPTH)+1; OverflowSticky  output  1; TimeoutSticky  output  1.

Function
REQ-015 Push: F2C_ReqValidQ502H with opcode RD or WR SHALL write {opcode, address, data} at the write pointer; all other opcodes SHALL be discarded with no response.
REQ-016 Push while full SHALL be dropped and set OverflowSticky, except when a pop occurs in the same cycle, in which case the push SHALL be accepted.
REQ-017 Pointers SHALL wrap modulo DEPTH; QueueCount SHALL be 0..DEPTH, with simultaneous push+pop leaving it unchanged.
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT_RD, RSP.
REQ-019 IDLE -> ISSUE when QueueCount>0; a push into an empty idle queue in cycle N SHALL give PrphReqValid=1 in cycle N+2.
REQ-020 In ISSUE, PrphReqValid=1 with the head entry on PrphReq*; PrphReqWr=1 for WR. All PrphReq* SHALL hold stable until PrphReqReady.
REQ-021 On acceptance, the head SHALL pop in that cycle: WR -> RSP; RD -> WAIT_RD.
REQ-022 In WAIT_RD, PrphRdDataValid in cycle K SHALL capture PrphRdData and enter RSP in cycle K+1.
REQ-023 In WAIT_RD, reaching RD_TIMEOUT cycles without PrphRdDataValid SHALL enter RSP with data 32'hDEAD_BEEF and set TimeoutSticky.
REQ-024 PrphRdDataValid outside WAIT_RD SHALL be ignored.
REQ-025 In RSP, F2C_RspValidQ500H=1 for exactly one cycle with RD_RSP+captured data or WR_RSP+data 0, and the accepted address; the next state SHALL be IDLE.
REQ-026 Responses SHALL return in request order, with one outstanding peripheral request at most.
REQ-027 F2C_Rsp* outputs other than valid SHALL be 0 whenever F2C_RspValidQ500H=0.

Reset
REQ-028 RstQnnnH=1 at any edge, including mid-transaction, SHALL empty the queue and set FSM=IDLE, pointers=0, timeout counter=0.
REQ-029 Reset SHALL set all outputs to 0, including both sticky flags; in-flight requests SHALL be abandoned without a response.
REQ-030 Sticky flags SHALL clear only on reset.

Verification
REQ-031 WR addr 0x0040_0010 data 0x5A into empty queue, PrphReqReady=1 -> PrphReqValid in cycle N+2, PrphReqWr=1; WR_RSP addr 0x0040_0010 data 0 in cycle N+3.
REQ-032 RD addr 0x0040_0020, ready=1, PrphRdDataValid 3 cycles after accept with 0x1234 -> single RD_RSP carrying 0x1234 the cycle after the return.
REQ-033 With PrphReqReady=0, push 5 requests -> QueueCount=4, OverflowSticky=1; then release ready -> 4 responses in order; the 5th is never seen.
REQ-034 Queue full with a pop in the same cycle as a push -> push accepted, QueueCount stays 4, OverflowSticky stays 0.
REQ-035 RD with no read return -> RD_RSP with 0xDEAD_BEEF after 255 WAIT_RD cycles and TimeoutSticky=1; a late PrphRdDataValid is ignored.
REQ-036 Reset in WAIT_RD with 2 entries queued -> next cycle QueueCount=0, no response, all outputs 0; a new WR then completes normally.
